// File: rtl/pkg_complex_counter.sv
// rtl/pkg_complex_counter.sv - count mode encoding shared by the counter and its users
package pkg_complex_counter;
    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_UP   = 2'd1,
        CNT_DOWN = 2'd2,
        CNT_LOAD = 2'd3
    } count_mode_t;
endpackage

// File: rtl/bounded_step_counter.sv
// rtl/bounded_step_counter.sv - step counter with runtime limits, wrap/saturate policy, event pulses
// Optional sticky event flag: define BOUNDED_CNT_STICKY_EN.
module bounded_step_counter
    import pkg_complex_counter::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  count_mode_t      mode,
    input  logic [WIDTH-1:0] stp,
    input  logic [WIDTH-1:0] ld,
    input  logic [WIDTH-1:0] lo_lim,
    input  logic [WIDTH-1:0] hi_lim,
    input  logic             wrap_en,
`ifdef BOUNDED_CNT_STICKY_EN
    input  logic             clr_sticky,
    output logic             evt_sticky,
`endif
    output logic [WIDTH-1:0] out,
    output logic             at_hi,
    output logic             at_lo,
    output logic             wrap_pulse,
    output logic             sat_pulse,
    output logic             cfg_err
);

    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] nxt_out;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic             nxt_wrap;
    logic             nxt_sat;

    assign at_hi   = (out == hi_lim);
    assign at_lo   = (out == lo_lim);
    assign cfg_err = (lo_lim > hi_lim);

    always_comb begin
        // Stepping starts from the nearest legal bound when out has drifted outside the range
        base = out;
        if (out < lo_lim) begin
            base = lo_lim;
        end else if (out > hi_lim) begin
            base = hi_lim;
        end
        sum      = {1'b0, base} + {1'b0, stp};
        diff     = {1'b0, base} - {1'b0, stp};
        nxt_out  = out;
        nxt_wrap = 1'b0;
        nxt_sat  = 1'b0;
        if (!cfg_err) begin
            case (mode)
                CNT_UP: begin
                    if (sum > {1'b0, hi_lim}) begin
                        if (wrap_en) begin
                            nxt_out  = lo_lim;
                            nxt_wrap = 1'b1;
                        end else begin
                            nxt_out  = hi_lim;
                            nxt_sat  = 1'b1;
                        end
                    end else begin
                        nxt_out = sum[WIDTH-1:0];
                    end
                end
                CNT_DOWN: begin
                    if (diff[WIDTH] || (diff[WIDTH-1:0] < lo_lim)) begin
                        if (wrap_en) begin
                            nxt_out  = hi_lim;
                            nxt_wrap = 1'b1;
                        end else begin
                            nxt_out  = lo_lim;
                            nxt_sat  = 1'b1;
                        end
                    end else begin
                        nxt_out = diff[WIDTH-1:0];
                    end
                end
                CNT_LOAD: begin
                    if (ld < lo_lim) begin
                        nxt_out = lo_lim;
                        nxt_sat = 1'b1;
                    end else if (ld > hi_lim) begin
                        nxt_out = hi_lim;
                        nxt_sat = 1'b1;
                    end else begin
                        nxt_out = ld;
                    end
                end
                default: begin
                    nxt_out = out;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out        <= RST_VAL;
            wrap_pulse <= 1'b0;
            sat_pulse  <= 1'b0;
        end else begin
            out        <= nxt_out;
            wrap_pulse <= nxt_wrap;
            sat_pulse  <= nxt_sat;
        end
    end

`ifdef BOUNDED_CNT_STICKY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_sticky <= 1'b0;
        end else if (nxt_wrap || nxt_sat) begin
            evt_sticky <= 1'b1;
        end else if (clr_sticky) begin
            evt_sticky <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_bounded_step_counter.sv
// tb/tb_bounded_step_counter.sv - scoreboard bench for bounded_step_counter with a reference model
module tb_bounded_step_counter;
    import pkg_complex_counter::*;

    typedef struct {
        int out;
        bit wrap;
        bit sat;
        bit sticky;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    count_mode_t mode;
    logic [7:0]  stp, ld, lo_lim, hi_lim;
    logic        wrap_en;
    logic        clr_sticky;
    logic [7:0]  out;
    logic        at_hi, at_lo, wrap_pulse, sat_pulse, cfg_err;
    logic        evt_sticky;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   m_out = 0;
    bit   m_sticky = 1'b0;

    always #5 clk = ~clk;

    bounded_step_counter #(.WIDTH(8), .RST_VAL(8'd0)) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .stp        (stp),
        .ld         (ld),
        .lo_lim     (lo_lim),
        .hi_lim     (hi_lim),
        .wrap_en    (wrap_en),
`ifdef BOUNDED_CNT_STICKY_EN
        .clr_sticky (clr_sticky),
        .evt_sticky (evt_sticky),
`endif
        .out        (out),
        .at_hi      (at_hi),
        .at_lo      (at_lo),
        .wrap_pulse (wrap_pulse),
        .sat_pulse  (sat_pulse),
        .cfg_err    (cfg_err)
    );

`ifndef BOUNDED_CNT_STICKY_EN
    assign evt_sticky = 1'b0;
`endif

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d at %0t", name, act, req, $time);
        end
    endtask

    // Apply one cycle of stimulus and queue the result the counter must show after the next edge
    task automatic step(input count_mode_t m, input int st, input int l, input int lo, input int hi,
                        input bit wr, input bit r, input bit clr);
        exp_t e;
        int   b, v;
        bit   ew, es;
        rst = r; mode = m; stp = 8'(st); ld = 8'(l);
        lo_lim = 8'(lo); hi_lim = 8'(hi); wrap_en = wr; clr_sticky = clr;
        ew = 0; es = 0; v = m_out;
        if (lo <= hi) begin
            b = (m_out < lo) ? lo : (m_out > hi) ? hi : m_out;
            if (m == CNT_UP) begin
                v = b + st;
                if (v > hi) begin v = wr ? lo : hi; ew = wr; es = !wr; end
            end else if (m == CNT_DOWN) begin
                v = b - st;
                if (v < lo) begin v = wr ? hi : lo; ew = wr; es = !wr; end
            end else if (m == CNT_LOAD) begin
                v = l;
                if (l < lo) begin v = lo; es = 1; end
                else if (l > hi) begin v = hi; es = 1; end
            end
        end
        if (r) begin
            v = 0; ew = 0; es = 0; m_sticky = 0;
        end else if (ew || es) begin
            m_sticky = 1;
        end else if (clr) begin
            m_sticky = 0;
        end
        m_out = v;
        e.out = v; e.wrap = ew; e.sat = es; e.sticky = m_sticky;
        q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("out", int'(out), e.out);
            check("wrap_pulse", int'(wrap_pulse), int'(e.wrap));
            check("sat_pulse", int'(sat_pulse), int'(e.sat));
            check("at_hi", int'(at_hi), int'(e.out == int'(hi_lim)));
            check("at_lo", int'(at_lo), int'(e.out == int'(lo_lim)));
            check("cfg_err", int'(cfg_err), int'(lo_lim > hi_lim));
`ifdef BOUNDED_CNT_STICKY_EN
            check("evt_sticky", int'(evt_sticky), int'(e.sticky));
`endif
        end
    end

    initial begin
        int lo, hi;
        step(CNT_UP, 5, 0, 0, 255, 1, 1, 0);
        step(CNT_UP, 5, 0, 0, 255, 1, 1, 0);
        step(CNT_UP, 5, 0, 0, 255, 1, 0, 0);
        step(CNT_LOAD, 0, 18, 10, 20, 1, 0, 0);
        step(CNT_UP, 3, 0, 10, 20, 1, 0, 0);
        step(CNT_HOLD, 0, 0, 10, 20, 1, 0, 0);
        step(CNT_LOAD, 0, 18, 10, 20, 1, 0, 0);
        step(CNT_UP, 2, 0, 10, 20, 1, 0, 1);
        step(CNT_LOAD, 0, 12, 10, 20, 0, 0, 0);
        step(CNT_DOWN, 5, 0, 10, 20, 0, 0, 0);
        step(CNT_DOWN, 5, 0, 10, 20, 0, 0, 0);
        step(CNT_UP, 0, 0, 10, 20, 0, 0, 1);
        step(CNT_LOAD, 0, 250, 0, 255, 1, 0, 0);
        step(CNT_UP, 10, 0, 0, 255, 1, 0, 0);
        step(CNT_DOWN, 1, 0, 0, 255, 1, 0, 0);
        step(CNT_LOAD, 0, 15, 10, 20, 1, 0, 0);
        step(CNT_LOAD, 0, 200, 10, 20, 1, 0, 0);
        step(CNT_LOAD, 0, 3, 10, 20, 1, 0, 0);
        step(CNT_UP, 1, 0, 30, 20, 1, 0, 0);
        step(CNT_DOWN, 4, 0, 30, 20, 1, 0, 0);
        step(CNT_UP, 1, 0, 10, 20, 1, 0, 0);
        step(CNT_HOLD, 0, 0, 40, 60, 1, 0, 0);
        step(CNT_UP, 0, 0, 40, 60, 1, 0, 0);
        step(CNT_DOWN, 0, 0, 50, 55, 1, 0, 0);
        lo = 10; hi = 20;
        for (int i = 0; i < 600; i++) begin
            int st;
            if ($urandom_range(0, 7) == 0) begin
                lo = $urandom_range(0, 255);
                hi = lo + $urandom_range(0, 255 - lo);
                if ($urandom_range(0, 9) == 0) begin
                    int t;
                    t = lo; lo = hi + 1; hi = t;
                    if (lo > 255) lo = 0;
                end
            end
            st = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 8) : $urandom_range(0, 255);
            step(count_mode_t'($urandom_range(0, 3)), st, $urandom_range(0, 255), lo, hi,
                 1'($urandom_range(0, 1)), ($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 5) == 0));
        end
        @(negedge clk);
        #1;
        check("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
